// File: rtl/branch_cond_unit.sv
// Two-stage conditional-branch evaluator: stage 1 captures the condition code and operand flags, stage 2 updates the held condition q.
// Optional BRANCH_COND_STATS_EN adds saturating eval_count / taken_count outputs.
module branch_cond_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int IR_WIDTH   = 32,
    parameter int COND_LSB   = 19
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic [IR_WIDTH-1:0]   ir,
    input  logic [DATA_WIDTH-1:0] bus_contents,
    input  logic                  con_in,
    input  logic                  flush,
`ifdef BRANCH_COND_STATS_EN
    output logic [15:0]           eval_count,
    output logic [15:0]           taken_count,
`endif
    output logic                  q,
    output logic                  q_valid,
    output logic                  pending
);

    // Handshake: con_in is a request sampled every edge with no back-pressure;
    // q_valid is a one-cycle pulse meaning q changed at the preceding edge.
    logic [2:0] cond_code;
    logic       op_z;
    logic       op_n;
    logic [2:0] s1_cond;
    logic       s1_z;
    logic       s1_n;
    logic       eval_q;
    logic       capture;
    logic       commit;
    logic       unused_ir;

    assign cond_code = ir[COND_LSB+2:COND_LSB];
    assign op_z      = (bus_contents == '0);
    assign op_n      = bus_contents[DATA_WIDTH-1];
    assign unused_ir = ^ir;

    assign capture = con_in & ~flush;
    assign commit  = pending & ~flush;

    always_comb begin
        eval_q = 1'b0;
        case (s1_cond)
            3'b000:  eval_q = s1_z;
            3'b001:  eval_q = ~s1_z;
            3'b010:  eval_q = ~s1_n;
            3'b011:  eval_q = s1_n;
            3'b100:  eval_q = ~s1_n & ~s1_z;
            3'b101:  eval_q = s1_n | s1_z;
            3'b110:  eval_q = 1'b1;
            default: eval_q = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            s1_cond <= 3'b000;
            s1_z    <= 1'b0;
            s1_n    <= 1'b0;
            pending <= 1'b0;
        end else begin
            pending <= capture;
            // Flags are frozen here so later bus activity cannot alter the result.
            if (capture) begin
                s1_cond <= cond_code;
                s1_z    <= op_z;
                s1_n    <= op_n;
            end
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            q       <= 1'b0;
            q_valid <= 1'b0;
        end else begin
            q_valid <= commit;
            if (commit) begin
                q <= eval_q;
            end
        end
    end

`ifdef BRANCH_COND_STATS_EN
    // Counters advance on the same edge that raises q_valid.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            eval_count  <= 16'h0000;
            taken_count <= 16'h0000;
        end else if (commit) begin
            if (eval_count != 16'hFFFF) begin
                eval_count <= eval_count + 16'd1;
            end
            if (eval_q && (taken_count != 16'hFFFF)) begin
                taken_count <= taken_count + 16'd1;
            end
        end
    end
`endif

endmodule
